// File: rtl/mult_issue_queue_pkg.sv
// mult_issue_queue_pkg: shared types and constants for the MULT issue queue
// Provides the reservation-station payload, EBR dependency tags, the queue
// entry layout and the squash-match helper used for dispatch and stored entries.
package mult_issue_queue_pkg;
    localparam int PHYS_REG_W    = 6;
    localparam int EBR_NUM       = 4;
    localparam int ROB_DEPTH     = 16;
    localparam int EBR_W         = $clog2(EBR_NUM);
    localparam int ROB_TAG_W     = $clog2(ROB_DEPTH) + 1;
    localparam int MULT_IQ_DEPTH = 4;

    typedef struct packed {
        logic [EBR_NUM-1:0]                valid;
        logic [EBR_NUM-1:0][ROB_TAG_W-1:0] rob_tags;
    } depen_t;

    typedef struct packed {
        logic [PHYS_REG_W-1:0]  ps1_idx;
        logic [PHYS_REG_W-1:0]  ps2_idx;
        logic [PHYS_REG_W-1:0]  pd_idx;
        logic [ROB_TAG_W-2:0]   rob_idx;
        depen_t                 depen;
        logic [EBR_NUM-1:0]     ctrl_block;
        logic [31:0]            inst;
        logic [31:0]            pc;
    } res_station_t;

    typedef struct packed {
        logic         valid;
        res_station_t rs;
        logic [31:0]  src1_v;
        logic         src1_rdy;
        logic [31:0]  src2_v;
        logic         src2_rdy;
    } mult_iq_entry_t;

    // An op dies on recovery of EBR slot ri when it depends on that slot and
    // its recorded branch tag is the mispredicted one.
    function automatic logic squashed(depen_t d, logic [EBR_W-1:0] ri, logic [ROB_TAG_W-1:0] tag);
        return d.valid[ri] && d.rob_tags[ri] == tag;
    endfunction
endpackage

// File: rtl/mult_iq_picker.sv
// mult_iq_picker: oldest-ready priority select over the issue queue
// ready : per-slot ready vector, slot 0 oldest
// idx   : lowest ready slot (0 when none)
// found : at least one slot is ready
module mult_iq_picker #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         ready,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                idx   = i[$clog2(DEPTH)-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_issue_queue.sv
// mult_issue_queue: age-ordered issue queue feeding the sequential MULT unit
// Dispatch side : dispatch_valid/dispatch_rs/dispatch_src*_v/_rdy in, dispatch_ready out
// Wakeup        : cdb_valid/cdb_pd_idx/cdb_value snooped every cycle
// Recovery      : flush with recover_idx/depen_rob squashes dependent entries
// Issue side    : mult_ready in, issue_valid/issue_a/issue_b/issue_rs out
module mult_issue_queue
    import mult_issue_queue_pkg::*;
#(
    parameter int DEPTH = MULT_IQ_DEPTH,
    parameter int N_CDB = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 dispatch_valid,
    input  res_station_t                         dispatch_rs,
    input  logic [31:0]                          dispatch_src1_v,
    input  logic [31:0]                          dispatch_src2_v,
    input  logic                                 dispatch_src1_rdy,
    input  logic                                 dispatch_src2_rdy,
    output logic                                 dispatch_ready,
    input  logic [N_CDB-1:0]                     cdb_valid,
    input  logic [N_CDB-1:0][PHYS_REG_W-1:0]     cdb_pd_idx,
    input  logic [N_CDB-1:0][31:0]               cdb_value,
    input  logic                                 flush,
    input  logic [EBR_W-1:0]                     recover_idx,
    input  logic [ROB_TAG_W-1:0]                 depen_rob,
    input  logic                                 mult_ready,
    output logic                                 issue_valid,
    output logic [31:0]                          issue_a,
    output logic [31:0]                          issue_b,
    output res_station_t                         issue_rs
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    mult_iq_entry_t q [DEPTH];
    mult_iq_entry_t nq [DEPTH];
    mult_iq_entry_t disp_e;
    logic [CW-1:0]  count, count_n, fill;
    logic [DEPTH-1:0] rdy_vec, kill;
    logic [IW-1:0]  sel;
    logic           found, mult_ready_q, live, flush_en, kill_disp;

    // Descending scan so the lowest matching CDB port is the one that sticks.
    function automatic mult_iq_entry_t wake(mult_iq_entry_t e);
        mult_iq_entry_t w = e;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (!e.src1_rdy && cdb_valid[k] && cdb_pd_idx[k] == e.rs.ps1_idx && e.rs.ps1_idx != '0) begin
                w.src1_rdy = 1'b1;
                w.src1_v   = cdb_value[k];
            end
            if (!e.src2_rdy && cdb_valid[k] && cdb_pd_idx[k] == e.rs.ps2_idx && e.rs.ps2_idx != '0) begin
                w.src2_rdy = 1'b1;
                w.src2_v   = cdb_value[k];
            end
        end
        return w;
    endfunction

    // live is low until the first edge after reset, masking a flush that
    // arrives in the same cycle reset is released.
    assign flush_en = flush & live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = q[i].valid & q[i].src1_rdy & q[i].src2_rdy;
            kill[i]    = flush_en & q[i].valid & squashed(q[i].rs.depen, recover_idx, depen_rob);
        end
    end

    mult_iq_picker #(.DEPTH(DEPTH)) u_picker (
        .ready (rdy_vec),
        .idx   (sel),
        .found (found)
    );

    // Registered MULT.ready breaks the combinational path into MULT.
    assign issue_valid    = mult_ready_q & found & ~kill[sel];
    assign dispatch_ready = count < CW'(DEPTH);
    assign issue_a        = issue_valid ? q[sel].src1_v : '0;
    assign issue_b        = issue_valid ? q[sel].src2_v : '0;
    assign issue_rs       = issue_valid ? q[sel].rs : '0;

    assign disp_e = '{valid: 1'b1, rs: dispatch_rs, src1_v: dispatch_src1_v, src1_rdy: dispatch_src1_rdy,
                      src2_v: dispatch_src2_v, src2_rdy: dispatch_src2_rdy};
    assign kill_disp = flush_en & squashed(dispatch_rs.depen, recover_idx, depen_rob);

    // Survivors are packed down in age order, then the new op lands at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) nq[i] = '0;
        fill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !kill[i] && !(issue_valid && sel == IW'(i))) begin
                nq[IW'(fill)] = wake(q[i]);
                fill          = fill + 1'b1;
            end
        end
        if (dispatch_valid && dispatch_ready && !kill_disp) begin
            nq[IW'(fill)] = wake(disp_e);
            fill          = fill + 1'b1;
        end
        count_n = fill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q            <= '{default: '0};
            count        <= '0;
            mult_ready_q <= 1'b1;
            live         <= 1'b0;
        end else begin
            q            <= nq;
            count        <= count_n;
            mult_ready_q <= mult_ready;
            live         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_issue_queue.sv
// tb_mult_issue_queue: self-checking bench for mult_issue_queue against a queue-based reference model
module tb_mult_issue_queue;
    import mult_issue_queue_pkg::*;
    localparam int DEPTH = MULT_IQ_DEPTH;
    localparam int N_CDB = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic dispatch_valid;
    res_station_t dispatch_rs;
    logic [31:0] dispatch_src1_v, dispatch_src2_v;
    logic dispatch_src1_rdy, dispatch_src2_rdy, dispatch_ready;
    logic [N_CDB-1:0] cdb_valid;
    logic [N_CDB-1:0][PHYS_REG_W-1:0] cdb_pd_idx;
    logic [N_CDB-1:0][31:0] cdb_value;
    logic flush;
    logic [EBR_W-1:0] recover_idx;
    logic [ROB_TAG_W-1:0] depen_rob;
    logic mult_ready, issue_valid;
    logic [31:0] issue_a, issue_b;
    res_station_t issue_rs;

    always #5 clk = ~clk;

    mult_issue_queue #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
        .clk(clk), .rst_n(rst_n),
        .dispatch_valid(dispatch_valid), .dispatch_rs(dispatch_rs),
        .dispatch_src1_v(dispatch_src1_v), .dispatch_src2_v(dispatch_src2_v),
        .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
        .dispatch_ready(dispatch_ready),
        .cdb_valid(cdb_valid), .cdb_pd_idx(cdb_pd_idx), .cdb_value(cdb_value),
        .flush(flush), .recover_idx(recover_idx), .depen_rob(depen_rob),
        .mult_ready(mult_ready), .issue_valid(issue_valid),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rs(issue_rs)
    );

    typedef struct {
        res_station_t rs;
        logic [31:0]  a, b;
        bit           ar, br;
    } op_t;

    op_t mq[$];
    bit mrq = 1'b1;
    bit flush_ok = 1'b0;
    int tests = 0;
    int fails = 0;
    int pick;
    logic exp_ready, exp_iv;
    logic [31:0] exp_a, exp_b;
    res_station_t exp_rs;

    function automatic bit doomed(res_station_t rs);
        return flush && flush_ok && rs.depen.valid[recover_idx] && rs.depen.rob_tags[recover_idx] == depen_rob;
    endfunction

    function automatic op_t woken(op_t o);
        for (int k = 0; k < N_CDB; k++) begin
            if (!o.ar && cdb_valid[k] && o.rs.ps1_idx != 0 && cdb_pd_idx[k] == o.rs.ps1_idx) begin
                o.ar = 1'b1;
                o.a  = cdb_value[k];
            end
            if (!o.br && cdb_valid[k] && o.rs.ps2_idx != 0 && cdb_pd_idx[k] == o.rs.ps2_idx) begin
                o.br = 1'b1;
                o.b  = cdb_value[k];
            end
        end
        return o;
    endfunction

    function automatic res_station_t mk(int ps1, int ps2, logic [31:0] pc, logic tagv, int tag);
        res_station_t r = '0;
        r.ps1_idx              = PHYS_REG_W'(ps1);
        r.ps2_idx              = PHYS_REG_W'(ps2);
        r.pd_idx               = PHYS_REG_W'(ps1 + ps2 + 1);
        r.depen.valid[2]       = tagv;
        r.depen.rob_tags[2]    = ROB_TAG_W'(tag);
        r.inst                 = 32'h02b50533;
        r.pc                   = pc;
        return r;
    endfunction

    function automatic res_station_t rand_rs();
        res_station_t r = '0;
        r.ps1_idx     = PHYS_REG_W'($urandom_range(0, 7));
        r.ps2_idx     = PHYS_REG_W'($urandom_range(0, 7));
        r.pd_idx      = PHYS_REG_W'($urandom_range(0, 63));
        r.rob_idx     = (ROB_TAG_W-1)'($urandom_range(0, 15));
        r.depen.valid = EBR_NUM'($urandom_range(0, 15));
        for (int e = 0; e < EBR_NUM; e++) r.depen.rob_tags[e] = ROB_TAG_W'($urandom_range(0, 3));
        r.ctrl_block  = EBR_NUM'($urandom_range(0, 15));
        r.inst        = $urandom;
        r.pc          = $urandom;
        return r;
    endfunction

    task automatic clear_in();
        dispatch_valid = 1'b0; dispatch_rs = '0;
        dispatch_src1_v = '0; dispatch_src2_v = '0;
        dispatch_src1_rdy = 1'b0; dispatch_src2_rdy = 1'b0;
        cdb_valid = '0; cdb_pd_idx = '0; cdb_value = '0;
        flush = 1'b0; recover_idx = '0; depen_rob = '0;
    endtask

    task automatic disp(res_station_t rs, logic [31:0] a, logic ar, logic [31:0] b, logic br);
        dispatch_valid = 1'b1; dispatch_rs = rs;
        dispatch_src1_v = a; dispatch_src1_rdy = ar;
        dispatch_src2_v = b; dispatch_src2_rdy = br;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mrq = 1'b1;
        flush_ok = 1'b0;
    endtask

    // Expected outputs for the current inputs: oldest op with both operands
    // in hand goes out, unless MULT was busy last cycle or the op is squashed.
    task automatic settle();
        #1;
        exp_ready = mq.size() < DEPTH;
        pick = -1;
        for (int i = 0; i < mq.size(); i++) if (pick < 0 && mq[i].ar && mq[i].br) pick = i;
        exp_iv = 1'b0; exp_a = '0; exp_b = '0; exp_rs = '0;
        if (pick >= 0 && mrq && !doomed(mq[pick].rs)) begin
            exp_iv = 1'b1; exp_a = mq[pick].a; exp_b = mq[pick].b; exp_rs = mq[pick].rs;
        end
    endtask

    task automatic tick();
        op_t nq[$];
        op_t d;
        for (int i = 0; i < mq.size(); i++)
            if (!doomed(mq[i].rs) && !(exp_iv && i == pick)) nq.push_back(woken(mq[i]));
        d.rs = dispatch_rs; d.a = dispatch_src1_v; d.ar = dispatch_src1_rdy;
        d.b = dispatch_src2_v; d.br = dispatch_src2_rdy;
        if (dispatch_valid && mq.size() < DEPTH && !doomed(d.rs)) nq.push_back(woken(d));
        @(posedge clk);
        mq = nq;
        mrq = mult_ready;
        flush_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_in();
        settle();
        tests++;
        if (dispatch_ready !== 1'b1 || issue_valid !== 1'b0 || issue_a !== 32'h0 || issue_b !== 32'h0 || issue_rs !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b iv=%b a=%h b=%h rs=%h, want rdy=1 iv=0 a/b/rs=0",
                     dispatch_ready, issue_valid, issue_a, issue_b, issue_rs);
        end
    endtask

    task automatic test_ready_at_dispatch();
        mult_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clear_in();
            if (c == 0) disp(mk(1, 2, 32'h100, 1'b0, 0), 32'd7, 1'b1, 32'hFFFFFFFD, 1'b1);
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL ready_at_dispatch c%0d: got rdy=%b iv=%b a=%h b=%h, want rdy=%b iv=%b a=%h b=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_b, exp_ready, exp_iv, exp_a, exp_b);
            end
            tests++;
            if (c == 1 && (issue_valid !== 1'b1 || issue_a !== 32'd7 || issue_b !== 32'hFFFFFFFD)) begin
                fails++;
                $display("FAIL ready_at_dispatch_values: got iv=%b a=%h b=%h, want iv=1 a=00000007 b=fffffffd",
                         issue_valid, issue_a, issue_b);
            end else if (c == 2 && (issue_valid !== 1'b0 || dispatch_ready !== 1'b1)) begin
                fails++;
                $display("FAIL ready_at_dispatch_empty: got iv=%b rdy=%b, want iv=0 rdy=1", issue_valid, dispatch_ready);
            end
            tick();
        end
    endtask

    task automatic test_cdb_wakeup();
        mult_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            clear_in();
            case (c)
                0: disp(mk(5, 6, 32'h200, 1'b0, 0), 32'h0, 1'b0, 32'd3, 1'b1);
                1: begin
                    cdb_valid = 2'b11;
                    cdb_pd_idx[0] = PHYS_REG_W'(9); cdb_value[0] = 32'hdead;
                    cdb_pd_idx[1] = PHYS_REG_W'(5); cdb_value[1] = 32'h1234;
                end
                3: disp(mk(0, 6, 32'h210, 1'b0, 0), 32'h0, 1'b0, 32'd4, 1'b1);
                default: if (c >= 4) begin
                    cdb_valid[0] = 1'b1; cdb_pd_idx[0] = '0; cdb_value[0] = 32'h55;
                end
            endcase
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL cdb_wakeup c%0d: got rdy=%b iv=%b a=%h b=%h, want rdy=%b iv=%b a=%h b=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_b, exp_ready, exp_iv, exp_a, exp_b);
            end
            tests++;
            if (c == 2 && (issue_valid !== 1'b1 || issue_a !== 32'h1234 || issue_b !== 32'd3)) begin
                fails++;
                $display("FAIL cdb_wakeup_capture: got iv=%b a=%h b=%h, want iv=1 a=00001234 b=00000003",
                         issue_valid, issue_a, issue_b);
            end else if (c != 2 && issue_valid !== 1'b0) begin
                fails++;
                $display("FAIL cdb_wakeup_no_issue c%0d: got iv=%b, want iv=0", c, issue_valid);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_full_age_order();
        mult_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            clear_in();
            if (c < 5) disp(mk(10 + c, 30, 32'h300 + 32'(c * 4), 1'b0, 0), 32'h0, 1'b0, 32'(c), 1'b1);
            if (c == 5) begin
                mult_ready = 1'b1;
                cdb_valid = 2'b11;
                cdb_pd_idx[0] = PHYS_REG_W'(12); cdb_value[0] = 32'hc2;
                cdb_pd_idx[1] = PHYS_REG_W'(10); cdb_value[1] = 32'hc0;
            end
            if (c == 8) begin
                cdb_valid = 2'b11;
                cdb_pd_idx[0] = PHYS_REG_W'(13); cdb_value[0] = 32'hc3;
                cdb_pd_idx[1] = PHYS_REG_W'(11); cdb_value[1] = 32'hc1;
            end
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL full_age_order c%0d: got rdy=%b iv=%b a=%h pc=%h, want rdy=%b iv=%b a=%h pc=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_rs.pc, exp_ready, exp_iv, exp_a, exp_rs.pc);
            end
            tests++;
            if (c == 4 && dispatch_ready !== 1'b0) begin
                fails++;
                $display("FAIL full_dispatch_ready: got %b, want 0", dispatch_ready);
            end else if (c == 6 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h300 || issue_a !== 32'hc0)) begin
                fails++;
                $display("FAIL age_order_first: got iv=%b pc=%h a=%h, want iv=1 pc=00000300 a=000000c0",
                         issue_valid, issue_rs.pc, issue_a);
            end else if (c == 7 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h308)) begin
                fails++;
                $display("FAIL age_order_second: got iv=%b pc=%h, want iv=1 pc=00000308", issue_valid, issue_rs.pc);
            end else if (c == 9 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h304)) begin
                fails++;
                $display("FAIL age_order_third: got iv=%b pc=%h, want iv=1 pc=00000304", issue_valid, issue_rs.pc);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_flush();
        mult_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            clear_in();
            recover_idx = EBR_W'(2); depen_rob = ROB_TAG_W'(5);
            if (c < 4) disp(mk(1, 2, 32'h400 + 32'(c * 4), 1'b1, (c % 2 == 1) ? 5 : 6), 32'(c + 1), 1'b1, 32'd2, 1'b1);
            if (c == 4) flush = 1'b1;
            if (c == 5) mult_ready = 1'b1;
            if (c == 9) disp(mk(1, 2, 32'h480, 1'b1, 5), 32'd9, 1'b1, 32'd9, 1'b1);
            if (c == 10) flush = 1'b1;
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL flush c%0d: got rdy=%b iv=%b a=%h pc=%h, want rdy=%b iv=%b a=%h pc=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_rs.pc, exp_ready, exp_iv, exp_a, exp_rs.pc);
            end
            tests++;
            if (c == 5 && dispatch_ready !== 1'b1) begin
                fails++;
                $display("FAIL flush_count: got dispatch_ready=%b, want 1", dispatch_ready);
            end else if (c == 6 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h400)) begin
                fails++;
                $display("FAIL flush_survivor0: got iv=%b pc=%h, want iv=1 pc=00000400", issue_valid, issue_rs.pc);
            end else if (c == 7 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h408)) begin
                fails++;
                $display("FAIL flush_survivor1: got iv=%b pc=%h, want iv=1 pc=00000408", issue_valid, issue_rs.pc);
            end else if ((c == 8 || c == 10 || c == 11) && issue_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_issue c%0d: got iv=%b, want 0", c, issue_valid);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_simultaneous();
        mult_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clear_in();
            if (c < 3) disp(mk(3, 4, 32'h500 + 32'(c * 4), 1'b0, 0), 32'(c), 1'b1, 32'(c), 1'b1);
            if (c == 3) mult_ready = 1'b1;
            if (c == 4) begin
                disp(mk(20, 21, 32'h5f0, 1'b0, 0), 32'h0, 1'b0, 32'hb, 1'b1);
                cdb_valid = 2'b11;
                cdb_pd_idx[0] = PHYS_REG_W'(20); cdb_value[0] = 32'ha;
                cdb_pd_idx[1] = PHYS_REG_W'(20); cdb_value[1] = 32'hbad;
            end
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL simultaneous c%0d: got rdy=%b iv=%b a=%h pc=%h, want rdy=%b iv=%b a=%h pc=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_rs.pc, exp_ready, exp_iv, exp_a, exp_rs.pc);
            end
            tests++;
            if (c == 4 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h500)) begin
                fails++;
                $display("FAIL simultaneous_issue: got iv=%b pc=%h, want iv=1 pc=00000500", issue_valid, issue_rs.pc);
            end else if (c == 7 && (issue_valid !== 1'b1 || issue_rs.pc !== 32'h5f0 || issue_a !== 32'ha || issue_b !== 32'hb)) begin
                fails++;
                $display("FAIL simultaneous_tail: got iv=%b pc=%h a=%h b=%h, want iv=1 pc=000005f0 a=0000000a b=0000000b",
                         issue_valid, issue_rs.pc, issue_a, issue_b);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear_in();
            if ($urandom_range(0, 1) == 1)
                disp(rand_rs(), $urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            for (int k = 0; k < N_CDB; k++) begin
                cdb_valid[k]  = 1'($urandom_range(0, 1));
                cdb_pd_idx[k] = PHYS_REG_W'($urandom_range(0, 7));
                cdb_value[k]  = $urandom;
            end
            flush       = ($urandom_range(0, 7) == 0);
            recover_idx = EBR_W'($urandom_range(0, EBR_NUM - 1));
            depen_rob   = ROB_TAG_W'($urandom_range(0, 3));
            mult_ready  = ($urandom_range(0, 9) < 7);
            settle();
            tests++;
            if ({dispatch_ready, issue_valid, issue_a, issue_b, issue_rs} !== {exp_ready, exp_iv, exp_a, exp_b, exp_rs}) begin
                fails++;
                $display("FAIL random c%0d: got rdy=%b iv=%b a=%h b=%h rs=%h, want rdy=%b iv=%b a=%h b=%h rs=%h",
                         c, dispatch_ready, issue_valid, issue_a, issue_b, issue_rs, exp_ready, exp_iv, exp_a, exp_b, exp_rs);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mult_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clear_in();
            if (c < 4) disp(mk(1, 2, 32'h600 + 32'(c * 4), 1'b0, 0), 32'(c + 1), 1'b1, 32'd5, 1'b1);
            if (c == 4) mult_ready = 1'b1;
            settle();
            tick();
        end
        clear_in();
        settle();
        tests++;
        if (issue_valid !== 1'b1 || dispatch_ready !== 1'b0 || issue_rs.pc !== 32'h600) begin
            fails++;
            $display("FAIL async_reset_pre: got iv=%b rdy=%b pc=%h, want iv=1 rdy=0 pc=00000600",
                     issue_valid, dispatch_ready, issue_rs.pc);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1 || issue_a !== 32'h0 || issue_rs !== '0) begin
            fails++;
            $display("FAIL async_reset_immediate: got iv=%b rdy=%b a=%h, want iv=0 rdy=1 a=0",
                     issue_valid, dispatch_ready, issue_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mrq = 1'b1;
        flush_ok = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests++;
            if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1 || exp_iv !== 1'b0) begin
                fails++;
                $display("FAIL async_reset_empty c%0d: got iv=%b rdy=%b, want iv=0 rdy=1", c, issue_valid, dispatch_ready);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mult_ready = 1'b1;
        clear_in();
        do_reset();
        test_reset();
        test_ready_at_dispatch();
        test_cdb_wakeup();
        test_full_age_order();
        test_flush();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
